// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants, select encoding and index helpers for multiply
//
// Purpose: single source for matrix geometry, the operation select encoding and
// the flattened-vector offset helpers used by multiply and its test bench.
// Ports: none (package).

package mult_pkg;

  localparam int N  = 4;   // matrix dimension
  localparam int W  = 16;  // input element width
  localparam int OW = 32;  // output element width

  typedef enum logic [1:0] {
    SEL_ADD  = 2'b00,
    SEL_EMUL = 2'b01,
    SEL_MMUL = 2'b10,
    SEL_MAC  = 2'b11
  } sel_e;

  // Bit offset of element (r,c) in a flattened input matrix.
  function automatic int in_idx(input int r, input int c);
    return (r * N + c) * W;
  endfunction

  // Bit offset of element (r,c) in the flattened result matrix.
  function automatic int out_idx(input int r, input int c);
    return (r * N + c) * OW;
  endfunction

endpackage

// File: rtl/dot4_u16.sv
// rtl/dot4_u16.sv - combinational 4-term unsigned 16x16 dot product
//
// Purpose: sum of four 16x16 unsigned products, truncated to 32 bits.
// Ports:
//   a_i    in  64  four 16-bit terms, term k at [k*16 +: 16]
//   b_i    in  64  four 16-bit terms, same layout as a_i
//   dot_o  out 32  sum_k a_i[k]*b_i[k], mod 2^32

import mult_pkg::*;

module dot4_u16 (
  input  logic [N*W-1:0] a_i,
  input  logic [N*W-1:0] b_i,
  output logic [OW-1:0]  dot_o
);

  logic [OW-1:0] prod [N];

  for (genvar k = 0; k < N; k++) begin : g_term
    assign prod[k] = {16'b0, a_i[k*W +: W]} * {16'b0, b_i[k*W +: W]};
  end

  // The 34-bit true sum is intentionally dropped to 32 bits by the adder width.
  assign dot_o = prod[0] + prod[1] + prod[2] + prod[3];

endmodule

// File: rtl/multiply.sv
// rtl/multiply.sv - 4x4 unsigned matrix ADD/EMUL/MMUL/MAC unit with registered result
//
// Purpose: every rising clk computes one 4x4 operation on dataa/datab selected by
// in_select and registers the 32-bit-per-element result; MAC accumulates into
// the result register itself.
// Ports:
//   clk        in  1    clock, rising edge
//   reset      in  1    asynchronous active-low reset, clears result
//   dataa      in  256  matrix A, element (r,c) at [(r*4+c)*16 +: 16]
//   datab      in  256  matrix B, same layout
//   in_select  in  2    00 ADD, 01 EMUL, 10 MMUL, 11 MAC
//   result     out 512  matrix R, element (r,c) at [(r*4+c)*32 +: 32]

import mult_pkg::*;

module multiply (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*N*W-1:0]   dataa,
  input  logic [N*N*W-1:0]   datab,
  input  logic [1:0]         in_select,
  output logic [N*N*OW-1:0]  result
);

  sel_e              sel;
  logic [N*N*OW-1:0] result_d;
  logic [N*N*OW-1:0] result_q;

  assign sel = sel_e'(in_select);

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      logic [W-1:0]   a_el;
      logic [W-1:0]   b_el;
      logic [N*W-1:0] row_a;
      logic [N*W-1:0] col_b;
      logic [OW-1:0]  sum_el;
      logic [OW-1:0]  prod_el;
      logic [OW-1:0]  dot_el;
      logic [OW-1:0]  mac_el;
      logic [OW-1:0]  elem_d;

      assign a_el = dataa[in_idx(r, c) +: W];
      assign b_el = datab[in_idx(r, c) +: W];

      // Row r of A against column c of B for the matrix product.
      for (genvar k = 0; k < N; k++) begin : g_k
        assign row_a[k*W +: W] = dataa[in_idx(r, k) +: W];
        assign col_b[k*W +: W] = datab[in_idx(k, c) +: W];
      end

      dot4_u16 u_dot (
        .a_i   (row_a),
        .b_i   (col_b),
        .dot_o (dot_el)
      );

      assign sum_el  = {15'b0, ({1'b0, a_el} + {1'b0, b_el})};
      assign prod_el = {16'b0, a_el} * {16'b0, b_el};
      // Accumulates onto the live register value, so MAC continues from
      // whatever the previous operation left behind.
      assign mac_el  = result_q[out_idx(r, c) +: OW] + prod_el;

      always_comb begin
        elem_d = sum_el;
        case (sel)
          SEL_ADD:  elem_d = sum_el;
          SEL_EMUL: elem_d = prod_el;
          SEL_MMUL: elem_d = dot_el;
          SEL_MAC:  elem_d = mac_el;
          default:  elem_d = sum_el;
        endcase
      end

      assign result_d[out_idx(r, c) +: OW] = elem_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_multiply.sv
// tb/tb_multiply.sv - directed self-checking bench for multiply

module tb_multiply;

  logic         clk;
  logic         reset;
  logic [255:0] dataa;
  logic [255:0] datab;
  logic [1:0]   in_select;
  logic [511:0] result;

  int tests_run = 0;
  int tests_failed = 0;

  multiply dut (
    .clk       (clk),
    .reset     (reset),
    .dataa     (dataa),
    .datab     (datab),
    .in_select (in_select),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] fill16(input logic [15:0] v);
    logic [255:0] m;
    for (int e = 0; e < 16; e++) m[e*16 +: 16] = v;
    return m;
  endfunction

  function automatic logic [511:0] fill32(input logic [31:0] v);
    logic [511:0] m;
    for (int e = 0; e < 16; e++) m[e*32 +: 32] = v;
    return m;
  endfunction

  // Reference matrix arithmetic, written directly from the operation definitions.
  function automatic logic [511:0] model(input logic [1:0] s, input logic [255:0] a,
                                         input logic [255:0] b, input logic [511:0] prev);
    logic [511:0] m;
    logic [31:0]  x, y, acc;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        x = {16'b0, a[(i*4+j)*16 +: 16]};
        y = {16'b0, b[(i*4+j)*16 +: 16]};
        case (s)
          2'b00: acc = x + y;
          2'b01: acc = x * y;
          2'b10: begin
            acc = 32'd0;
            for (int k = 0; k < 4; k++)
              acc = acc + {16'b0, a[(i*4+k)*16 +: 16]} * {16'b0, b[(k*4+j)*16 +: 16]};
          end
          default: acc = prev[(i*4+j)*32 +: 32] + x * y;
        endcase
        m[(i*4+j)*32 +: 32] = acc;
      end
    end
    return m;
  endfunction

  task automatic check(input string tag, input logic [511:0] exp);
    tests_run++;
    assert (result === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, result, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    for (int e = 0; e < 8; e++) begin
      dataa[e*32 +: 32] = $urandom;
      datab[e*32 +: 32] = $urandom;
    end
    in_select = 2'($urandom_range(0, 3));
  endtask

  logic [255:0] ta, tb_m;
  logic [511:0] exp_m;

  initial begin
    reset = 1'b0;
    dataa = '0;
    datab = '0;
    in_select = 2'b00;

    // Reset held: result stays zero across edges whatever the inputs.
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      step();
      check($sformatf("reset_hold_%0d", i), '0);
    end

    reset = 1'b1;

    // MMUL: all ones times all twos -> 4*2 = 8.
    dataa = fill16(16'd1);
    datab = fill16(16'd2);
    in_select = 2'b10;
    step();
    check("mmul_ones_twos", fill32(32'd8));

    // MMUL: identity times B gives B.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        ta[(r*4+c)*16 +: 16]     = (r == c) ? 16'd1 : 16'd0;
        tb_m[(r*4+c)*16 +: 16]   = 16'(r*4 + c);
        exp_m[(r*4+c)*32 +: 32]  = 32'(r*4 + c);
      end
    end
    dataa = ta;
    datab = tb_m;
    step();
    check("mmul_identity", exp_m);

    // Maximum operands.
    dataa = fill16(16'hFFFF);
    datab = fill16(16'hFFFF);
    in_select = 2'b00;
    step();
    check("add_max", fill32(32'h0001_FFFE));
    in_select = 2'b01;
    step();
    check("emul_max", fill32(32'hFFFE_0001));
    in_select = 2'b10;
    step();
    check("mmul_max_trunc", fill32(32'hFFF8_0004));

    // Asynchronous reset between edges clears result with no clock edge.
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", '0);
    step();
    #2;
    reset = 1'b1;
    #1;

    // MAC from a freshly reset register: 3*5 accumulates.
    dataa = fill16(16'd3);
    datab = fill16(16'd5);
    in_select = 2'b11;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("mac_acc_%0d", i), fill32(32'(15 * i)));
    end

    // Build 0xFFFFFFF0 from 0xFFFE0001 + 15*8737, then wrap with +20.
    dataa = fill16(16'hFFFF);
    datab = fill16(16'hFFFF);
    in_select = 2'b01;
    step();
    check("wrap_seed_emul", fill32(32'hFFFE_0001));
    dataa = fill16(16'd15);
    datab = fill16(16'd8737);
    in_select = 2'b11;
    step();
    check("wrap_pre", fill32(32'hFFFF_FFF0));
    dataa = fill16(16'd4);
    datab = fill16(16'd5);
    step();
    check("wrap_mac", fill32(32'h0000_0004));

    // Select switching every cycle with ramping inputs.
    exp_m = result;
    for (int k = 1; k <= 6; k++) begin
      for (int e = 0; e < 16; e++) begin
        ta[e*16 +: 16]   = 16'(k + e);
        tb_m[e*16 +: 16] = 16'(2*k + e);
      end
      dataa = ta;
      datab = tb_m;
      in_select = 2'(k % 3);
      exp_m = model(2'(k % 3), ta, tb_m, exp_m);
      step();
      check($sformatf("switch_%0d", k), exp_m);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
